// File: rtl/truth_table_scanner_pkg.sv
// Shared definitions for the truth-table scanner.
//   - state_e      : scan controller states
//   - literals_t   : true/complement literal bundle for one input vector
//   - vec_literals : maps a vector index onto its literal bundle
package truth_table_scanner_pkg;

  localparam int NUM_VECTORS = 16;
  localparam int VEC_W       = 4;
  localparam int COUNT_W     = 5;
  // Wide enough for the largest settle time (15).
  localparam int SETTLE_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  typedef struct packed {
    logic a;
    logic ab;
    logic b;
    logic bb;
    logic c;
    logic d;
    logic db;
  } literals_t;

  // a is the MSB of the index and d the LSB; c has no complement output.
  function automatic literals_t vec_literals(input logic [VEC_W-1:0] idx);
    literals_t lit;
    lit.a  = idx[3];
    lit.ab = ~idx[3];
    lit.b  = idx[2];
    lit.bb = ~idx[2];
    lit.c  = idx[1];
    lit.d  = idx[0];
    lit.db = ~idx[0];
    return lit;
  endfunction

endpackage

// File: rtl/truth_table_scanner_if.sv
// Bus between the scanner and whoever controls it.
//   start, abort, f_in      : control and the response of the unit under test
//   a, ab, b, bb, c, d, db  : literals of the vector currently applied
//   busy, done              : scan status
//   minterm_mask            : sampled response, bit k for vector k
//   ones_count              : number of set bits in minterm_mask
// Modports: master drives start/abort/f_in, slave is the scanner.
interface truth_table_scanner_if;
  import truth_table_scanner_pkg::*;

  logic                   start;
  logic                   abort;
  logic                   f_in;
  logic                   a;
  logic                   ab;
  logic                   b;
  logic                   bb;
  logic                   c;
  logic                   d;
  logic                   db;
  logic                   busy;
  logic                   done;
  logic [NUM_VECTORS-1:0] minterm_mask;
  logic [COUNT_W-1:0]     ones_count;

  modport master (
    output start, abort, f_in,
    input  a, ab, b, bb, c, d, db, busy, done, minterm_mask, ones_count
  );

  modport slave (
    input  start, abort, f_in,
    output a, ab, b, bb, c, d, db, busy, done, minterm_mask, ones_count
  );

endinterface

// File: rtl/truth_table_scanner_settle_timer.sv
// Settle timer: a down-counter that is loaded with LOAD_VAL and counts to
// zero while enabled. The counter reads as expired once it reaches zero.
// A load of N therefore gives N+1 cycles up to and including the expiry cycle.
//   clk, rst_n : clock and asynchronous active-low reset
//   i_load     : reload the counter with LOAD_VAL (wins over i_en)
//   i_en       : count down by one (saturating at zero)
//   o_expired  : counter is zero
module truth_table_scanner_settle_timer #(
  parameter int unsigned       WIDTH    = 4,
  parameter logic [WIDTH-1:0]  LOAD_VAL = {WIDTH{1'b0}}
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);

  logic [WIDTH-1:0] r_count;

  // Down-counter with load priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= {WIDTH{1'b0}};
    end else if (i_load) begin
      r_count <= LOAD_VAL;
    end else if (i_en && (r_count != {WIDTH{1'b0}})) begin
      r_count <= r_count - WIDTH'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_expired = (r_count == {WIDTH{1'b0}});

endmodule

// File: rtl/truth_table_scanner.sv
// Truth-table scanner: walks the 16 input vectors of a 4-input combinational
// unit, waits SETTLE cycles per vector, samples its response f_in and builds
// the minterm mask plus a population count.
//   SETTLE : settle cycles per vector (1..15)
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of truth_table_scanner_if
// All outputs come straight from flops; f_in only reaches the mask/count
// registers, so there is no combinational path from f_in to any output.
module truth_table_scanner
  import truth_table_scanner_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  truth_table_scanner_if.slave bus
);

  localparam logic [VEC_W-1:0]    LAST_IDX   = VEC_W'(NUM_VECTORS - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LDV = SETTLE_W'(SETTLE - 1);

  state_e                 r_state;
  logic [VEC_W-1:0]       r_idx;
  literals_t              r_lit;
  logic [NUM_VECTORS-1:0] r_mask;
  logic [COUNT_W-1:0]     r_ones;
  logic                   r_busy;
  logic                   r_done;

  logic                   w_start_ok;
  logic                   w_tmr_load;
  logic                   w_tmr_en;
  logic                   w_tmr_expired;

  // abort beats start when both arrive in IDLE.
  assign w_start_ok = bus.start && !bus.abort;

  // Settle timer control: reload on scan start and when moving to the next
  // vector, count while settling.
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_en   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) begin
          w_tmr_load = 1'b1;
        end else begin
          w_tmr_load = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (!bus.abort) begin
          w_tmr_en = 1'b1;
        end else begin
          w_tmr_en = 1'b0;
        end
      end
      ST_SAMPLE: begin
        if (!bus.abort && (r_idx != LAST_IDX)) begin
          w_tmr_load = 1'b1;
        end else begin
          w_tmr_load = 1'b0;
        end
      end
      default: begin
        w_tmr_load = 1'b0;
        w_tmr_en   = 1'b0;
      end
    endcase
  end

  truth_table_scanner_settle_timer #(
    .WIDTH    (SETTLE_W),
    .LOAD_VAL (SETTLE_LDV)
  ) u_settle_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_tmr_load),
    .i_en      (w_tmr_en),
    .o_expired (w_tmr_expired)
  );

  // Scan controller. busy is written with the next state so it tracks the
  // state register exactly; done is raised on the edge that leaves DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= {VEC_W{1'b0}};
      r_lit   <= vec_literals({VEC_W{1'b0}});
      r_mask  <= {NUM_VECTORS{1'b0}};
      r_ones  <= {COUNT_W{1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_state <= ST_SETTLE;
            r_idx   <= {VEC_W{1'b0}};
            r_lit   <= vec_literals({VEC_W{1'b0}});
            r_mask  <= {NUM_VECTORS{1'b0}};
            r_ones  <= {COUNT_W{1'b0}};
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (bus.abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_tmr_expired) begin
            r_state <= ST_SAMPLE;
          end else begin
            r_state <= ST_SETTLE;
          end
        end
        ST_SAMPLE: begin
          if (bus.abort) begin
            // The sample of this cycle is dropped.
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_mask[r_idx] <= bus.f_in;
            if (bus.f_in) begin
              r_ones <= r_ones + COUNT_W'(1);
            end else begin
              r_ones <= r_ones;
            end
            if (r_idx == LAST_IDX) begin
              // Index stays at 15; it never wraps inside a scan.
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_SETTLE;
              r_idx   <= r_idx + VEC_W'(1);
              r_lit   <= vec_literals(r_idx + VEC_W'(1));
            end
          end
        end
        ST_DONE: begin
          // abort is ignored here; the completion pulse always happens.
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.a            = r_lit.a;
  assign bus.ab           = r_lit.ab;
  assign bus.b            = r_lit.b;
  assign bus.bb           = r_lit.bb;
  assign bus.c            = r_lit.c;
  assign bus.d            = r_lit.d;
  assign bus.db           = r_lit.db;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.minterm_mask = r_mask;
  assign bus.ones_count   = r_ones;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Self-checking bench for truth_table_scanner. A SETTLE=2 instance is driven
// by a combinational "unit under test" built from a random 16-entry truth
// table (or the fixed function (a^b)&(c|~d)); a SETTLE=1 instance sees a
// constant f_in. Expectations come from the scan rules: vector k lands in
// mask bit k, each scan takes 16*(SETTLE+1)+1 cycles to done.
module tb_truth_table_scanner;

  localparam int S2      = 2;
  localparam int S1      = 1;
  localparam int LAT2    = 16 * (S2 + 1) + 1;
  localparam int LAT1    = 16 * (S1 + 1) + 1;

  logic        clk;
  logic        rst_n;
  logic        use_fn;
  logic [15:0] tt;
  logic        f1;

  int          n_total;
  int          n_bad;
  logic [15:0] last_exp_mask;
  int          last_exp_cnt;

  truth_table_scanner_if bus ();
  truth_table_scanner_if bus1 ();

  truth_table_scanner #(.SETTLE(S2)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  truth_table_scanner #(.SETTLE(S1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  assign bus.f_in  = use_fn ? ((bus.a ^ bus.b) & (bus.c | ~bus.d))
                            : tt[{bus.a, bus.b, bus.c, bus.d}];
  assign bus1.f_in = f1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] cur_vec();
    return {bus.a, bus.b, bus.c, bus.d};
  endfunction

  // One scan on the SETTLE=2 instance. abort_vec>=0 aborts in the first
  // settle cycle of that vector; repulse_cyc>0 re-pulses start mid-scan;
  // abort_done raises abort during the DONE cycle.
  task automatic run_scan(input int abort_vec, input int repulse_cyc,
                          input bit abort_done, input logic [15:0] exp_tt);
    int          n_done;
    int          done_cyc;
    int          limit;
    int          exp_cnt;
    bit          abort_sent;
    logic [3:0]  vec;
    logic [3:0]  prev_vec;
    logic [15:0] exp_mask;

    n_done     = 0;
    done_cyc   = -1;
    abort_sent = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    check_val("busy_rise", 32'(bus.busy), 32'd1);
    check_val("vec0", 32'(cur_vec()), 32'd0);
    prev_vec = 4'd0;
    for (int cyc = 1; cyc <= LAT2 + 6; cyc++) begin
      @(negedge clk);
      if (bus.abort) begin
        bus.abort = 1'b0;
        check_val("abort_busy", 32'(bus.busy), 32'd0);
      end
      bus.start = (cyc == repulse_cyc);
      if (abort_done && (cyc == LAT2 - 1)) bus.abort = 1'b1;
      if (bus.done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      vec = cur_vec();
      if (vec != prev_vec) begin
        check_val("vec_step", 32'(vec), 32'(prev_vec + 4'd1));
        check_val("lit_cmp", 32'({bus.ab, bus.bb, bus.db}), 32'({~bus.a, ~bus.b, ~bus.d}));
        prev_vec = vec;
      end
      if (!abort_sent && (abort_vec >= 0) && (int'(vec) == abort_vec)) begin
        bus.abort  = 1'b1;
        abort_sent = 1'b1;
      end
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;

    limit    = (abort_vec >= 0) ? abort_vec : 16;
    exp_mask = 16'h0000;
    for (int k = 0; k < limit; k++) exp_mask[k] = exp_tt[k];
    exp_cnt = $countones(exp_mask);

    if (abort_sent) begin
      check_val("abort_nodone", 32'(n_done), 32'd0);
    end else begin
      check_val("done_cnt", 32'(n_done), 32'd1);
      check_val("latency", 32'(done_cyc), 32'(LAT2));
      check_val("final_vec", 32'(cur_vec()), 32'd15);
    end
    check_val("mask", 32'(bus.minterm_mask), 32'(exp_mask));
    check_val("ones", 32'(bus.ones_count), 32'(exp_cnt));
    check_val("idle_busy", 32'(bus.busy), 32'd0);
    last_exp_mask = exp_mask;
    last_exp_cnt  = exp_cnt;
  endtask

  // One scan on the SETTLE=1 instance with constant f_in.
  task automatic run_s1(input logic fval, input logic [15:0] exp_mask, input int exp_cnt);
    int done_cyc;
    int n_done;
    f1       = fval;
    done_cyc = -1;
    n_done   = 0;
    @(negedge clk);
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    for (int i = 1; i <= LAT1 + 5; i++) begin
      @(negedge clk);
      if (bus1.done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = i;
      end
    end
    check_val("s1_latency", 32'(done_cyc), 32'(LAT1));
    check_val("s1_done_cnt", 32'(n_done), 32'd1);
    check_val("s1_mask", 32'(bus1.minterm_mask), 32'(exp_mask));
    check_val("s1_ones", 32'(bus1.ones_count), 32'(exp_cnt));
  endtask

  initial begin
    int n_done;
    int sel;
    n_total    = 0;
    n_bad      = 0;
    use_fn     = 1'b0;
    tt         = 16'h0000;
    f1         = 1'b0;
    bus.start  = 1'b0;
    bus.abort  = 1'b0;
    bus1.start = 1'b0;
    bus1.abort = 1'b0;
    rst_n      = 1'b1;
    #1 rst_n   = 1'b0;
    #2;
    // Reset state: literals a,ab,b,bb,c,d,db = 0,1,0,1,0,0,1.
    check_val("rst_lits", 32'({bus.a, bus.ab, bus.b, bus.bb, bus.c, bus.d, bus.db}), 32'h29);
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    check_val("rst_done", 32'(bus.done), 32'd0);
    check_val("rst_mask", 32'(bus.minterm_mask), 32'd0);
    check_val("rst_ones", 32'(bus.ones_count), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Fixed function (a^b)&(c|~d).
    use_fn = 1'b1;
    run_scan(-1, 0, 1'b0, 16'h0DD0);
    check_val("fn_mask", 32'(bus.minterm_mask), 32'h0DD0);
    check_val("fn_ones", 32'(bus.ones_count), 32'd6);

    // Abort while settling vector 5 with f_in=1.
    use_fn = 1'b0;
    tt     = 16'hFFFF;
    run_scan(5, 0, 1'b0, tt);
    check_val("abort5_mask", 32'(bus.minterm_mask), 32'h001F);
    check_val("abort5_ones", 32'(bus.ones_count), 32'd5);

    // start and abort together in IDLE: no scan, results held.
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check_val("sa_busy", 32'(bus.busy), 32'd0);
    repeat (4) @(negedge clk);
    check_val("sa_busy2", 32'(bus.busy), 32'd0);
    check_val("sa_hold_mask", 32'(bus.minterm_mask), 32'(last_exp_mask));
    check_val("sa_hold_ones", 32'(bus.ones_count), 32'(last_exp_cnt));

    // start re-pulsed at cycle 10 of a running scan.
    tt = 16'($urandom);
    run_scan(-1, 10, 1'b0, tt);

    // abort during the DONE cycle is ignored.
    tt = 16'($urandom);
    run_scan(-1, 0, 1'b1, tt);

    // Reset pulse mid-scan at vector 9.
    tt = 16'($urandom);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 60 && cur_vec() != 4'd9; i++) @(negedge clk);
    check_val("rst_reach9", 32'(cur_vec()), 32'd9);
    rst_n = 1'b0;
    #1;
    check_val("mrst_lits", 32'({bus.a, bus.ab, bus.b, bus.bb, bus.c, bus.d, bus.db}), 32'h29);
    check_val("mrst_busy", 32'(bus.busy), 32'd0);
    check_val("mrst_mask", 32'(bus.minterm_mask), 32'd0);
    check_val("mrst_ones", 32'(bus.ones_count), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    n_done = 0;
    for (int i = 0; i < LAT2 + 6; i++) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    check_val("mrst_nodone", 32'(n_done), 32'd0);
    run_scan(-1, 0, 1'b0, tt);

    // SETTLE=1 instance with f_in tied high, then low.
    run_s1(1'b1, 16'hFFFF, 16);
    run_s1(1'b0, 16'h0000, 0);

    // Randomized scans.
    for (int it = 0; it < 6; it++) begin
      tt  = 16'($urandom);
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       run_scan(-1, 0, 1'b0, tt);
        1:       run_scan(int'($urandom_range(1, 15)), 0, 1'b0, tt);
        2:       run_scan(-1, int'($urandom_range(2, 45)), 1'b0, tt);
        default: run_scan(-1, 0, 1'b1, tt);
      endcase
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/truth_table_scanner.md
TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

Interface
REQ-001 Parameter SETTLE, default 2: wait cycles between driving a vector and sampling f_in; legal range 1..15.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  begin a scan; honoured only in IDLE.
REQ-005 abort  input  1  terminate a scan in progress.
REQ-006 f_in  input  1  output of the combinational unit under test.
REQ-007 a, ab, b, bb, c, d, db  output  1 each  registered true/complement literals of the current vector.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse on scan completion.
REQ-010 minterm_mask  output  16  bit k holds the sampled f_in for vector k.
REQ-011 ones_count  output  5  number of set bits in minterm_mask (0..16).

Function
REQ-012 Vector index idx is 4 bits; a=idx[3], b=idx[2], c=idx[1], d=idx[0]; ab=~a, bb=~b, db=~d; all literals come from flops, glitch-free.
REQ-013 States: IDLE, SETTLE, SAMPLE, DONE.
REQ-014 IDLE with start=1: next cycle idx=0, settle counter=0, minterm_mask=0, ones_count=0, state=SETTLE.
REQ-015 SETTLE: counter increments each cycle; on the cycle the counter equals SETTLE-1, go to SAMPLE.
REQ-016 SAMPLE: minterm_mask[idx]<=f_in; ones_count increments when f_in=1; if idx=15 go to DONE, else idx<=idx+1, counter<=0, state=SETTLE.
REQ-017 idx never wraps within a scan; 15 is terminal.
REQ-018 DONE: done=1 for exactly that cycle; next state IDLE; idx holds at 15.
REQ-019 Latency: done asserts 16*(SETTLE+1)+1 cycles after the clock edge that samples start.
REQ-020 start while busy is ignored, with no effect on idx, mask or timing.
REQ-021 abort in SETTLE or SAMPLE: next state IDLE, no done pulse, partial minterm_mask/ones_count retained, current SAMPLE write suppressed.
REQ-022 abort and start together in IDLE: abort wins; the scan does not start.
REQ-023 abort in DONE: ignored; the done pulse still occurs.
REQ-024 minterm_mask and ones_count hold their values in IDLE until the next accepted start.

Reset
REQ-025 rst_n=0 forces, asynchronously: state=IDLE, idx=0, settle counter=0, minterm_mask=0, ones_count=0, busy=0, done=0.
REQ-026 Literal outputs under reset: a=b=c=d=0, ab=bb=db=1.
REQ-027 Reset asserted mid-scan abandons the scan; no done pulse follows deassertion.
REQ-028 Reset deassertion is synchronised externally; the first start is accepted on the first edge after release.

Structure
REQ-029 Shared package holds the state enum, NUM_VECTORS=16, VEC_W=4 and COUNT_W=5.
REQ-030 One sub-module, settle_timer: a parameterised down-counter with load/expire, instantiated once.
REQ-031 No combinational path from f_in to any output.

Verification
REQ-032 SETTLE=2; f_in driven by (a xor b) and (c or not d) from the literal outputs; pulse start -> done at cycle 49, minterm_mask=16'h0DD0, ones_count=6.
REQ-033 f_in tied 1, SETTLE=1 -> done at cycle 33, minterm_mask=16'hFFFF, ones_count=16; f_in tied 0 -> mask=16'h0000, count=0.
REQ-034 abort during the SETTLE phase of vector 5 with f_in=1 -> IDLE next cycle, busy=0, no done pulse, mask=16'h001F, count=5.
REQ-035 start re-pulsed at cycle 10 of a running scan -> timing and result identical to the uninterrupted scan; exactly one done pulse.
REQ-036 rst_n low for 1 cycle mid-scan at vector 9 -> all outputs at reset values immediately; no done; a fresh start then completes normally.
REQ-037 Literal check each SAMPLE: ab==~a, bb==~b, db==~d, and {a,b,c,d}==idx incrementing 0..15.
